// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and port indices for the SDRAM command-port arbiter.
package dram_port_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef logic [24:0] dram_addr_t;
  typedef logic [15:0] dram_word_t;

  localparam int DRAM_PORT_VGA  = 0;
  localparam int DRAM_PORT_CPU  = 1;
  localparam int DRAM_PORT_UART = 2;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/dram_tag_fifo.sv
// Small synchronous FIFO holding the issuing port id of each outstanding read.
module dram_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the SDRAM controller command port between requesters, with burst lock
// and in-order read-data steering.
//   state  | meaning
//   ARB    | pick a winner, register owner; never forwards a beat
//   LOCKED | forward owner's beats until the accepted last beat
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int ADDR_W     = $bits(dram_addr_t),
  parameter int DATA_W     = $bits(dram_word_t),
  parameter int RT_PORT    = DRAM_PORT_VGA,
  parameter int STARVE_MAX = 64,
  parameter int MAX_OUTST  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ctl_valid,
  input  logic                      ctl_ready,
  output logic                      ctl_we,
  output logic [ADDR_W-1:0]         ctl_addr,
  output logic [DATA_W-1:0]         ctl_wdata,
  input  logic                      ctl_rvalid,
  input  logic [DATA_W-1:0]         ctl_rdata,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      err_orphan
);

  localparam int OW = $clog2(N_REQ);
  localparam int WW = $clog2(STARVE_MAX + 1);
  localparam logic [OW-1:0] RT_ID    = OW'(RT_PORT);
  localparam logic [WW-1:0] WAIT_SAT = WW'(STARVE_MAX);

  arb_state_t    state;
  logic [OW-1:0] rr_ptr;
  logic [WW-1:0] wait_cnt [N_REQ];

  logic [OW-1:0] win;
  logic          win_rr;
  logic          starve_hit;
  logic          rr_hit;
  logic [OW-1:0] rr_win;
  int            rr_j;

  logic          tag_full;
  logic          tag_empty;
  logic [OW-1:0] tag_head;
  logic          blk;
  logic          accept;

  // Descending scans so the last hit, i.e. the nearest candidate, wins.
  always_comb begin
    win        = RT_ID;
    win_rr     = 1'b0;
    starve_hit = 1'b0;
    rr_hit     = 1'b0;
    rr_win     = RT_ID;
    rr_j       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i != RT_PORT && req_valid[i] && wait_cnt[i] == WAIT_SAT) begin
        win        = OW'(i);
        starve_hit = 1'b1;
      end
    end
    for (int k = N_REQ; k >= 1; k--) begin
      rr_j = wrap_idx(int'(rr_ptr), k, N_REQ);
      if (rr_j != RT_PORT && req_valid[rr_j]) begin
        rr_win = OW'(rr_j);
        rr_hit = 1'b1;
      end
    end
    if (starve_hit) begin
      win_rr = 1'b1;
    end else if (req_valid[RT_PORT]) begin
      win = RT_ID;
    end else if (rr_hit) begin
      win    = rr_win;
      win_rr = 1'b1;
    end
  end

  assign blk       = !req_we[owner] && tag_full;
  assign ctl_we    = req_we[owner];
  assign ctl_addr  = req_addr[int'(owner)*ADDR_W +: ADDR_W];
  assign ctl_wdata = req_wdata[int'(owner)*DATA_W +: DATA_W];
  assign accept    = ctl_valid && ctl_ready;

  always_comb begin
    ctl_valid = 1'b0;
    req_ready = '0;
    if (state == LOCKED) begin
      ctl_valid        = req_valid[owner] && !blk;
      req_ready[owner] = ctl_ready && !blk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB;
      owner  <= '0;
      rr_ptr <= RT_ID;
    end else begin
      unique case (state)
        ARB: begin
          if (|req_valid) begin
            owner <= win;
            state <= LOCKED;
            if (win_rr) rr_ptr <= win;
          end
        end
        LOCKED: begin
          if (accept && req_last[owner]) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  // The RT port never ages; its counter stays at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i == RT_PORT) begin
          wait_cnt[i] <= '0;
        end else if (state == ARB && (|req_valid) && win == OW'(i)) begin
          wait_cnt[i] <= '0;
        end else if (req_valid[i] && !(state == LOCKED && owner == OW'(i))
                     && wait_cnt[i] != WAIT_SAT) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  dram_tag_fifo #(
    .WIDTH (OW),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && !req_we[owner]),
    .push_data (owner),
    .pop       (ctl_rvalid),
    .full      (tag_full),
    .empty     (tag_empty),
    .head      (tag_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (ctl_rvalid) begin
        if (!tag_empty) begin
          rsp_valid[tag_head] <= 1'b1;
          rsp_rdata           <= ctl_rdata;
        end else begin
          err_orphan <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single SDRAM controller command port between N requesters: VGA line fetch (real-time), CPU data port and UART loader.
- Sits between the requesters and the SDRAM controller inside marvin.
- Arbitrates with real-time priority plus anti-starvation aging and round-robin among the other ports.
- Locks the grant for multi-beat bursts and routes in-order read data back to the issuing port via a tag FIFO.

Parameters:
- N_REQ, 3, number of requester ports (2..8).
- ADDR_W, 25, SDRAM word address width (32M x 16 bit).
- DATA_W, 16, data width.
- RT_PORT, 0, index of the real-time (highest-priority) port.
- STARVE_MAX, 64, wait cycles after which a non-RT port overrides RT priority.
- MAX_OUTST, 4, maximum outstanding reads (tag FIFO depth, power of 2).

Ports:
- clk  in  1  system clock (one clock domain).
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  request beat valid per port.
- req_ready  out  N_REQ  beat accepted when valid&&ready.
- req_we  in  N_REQ  1=write, 0=read, per port.
- req_last  in  N_REQ  final beat of burst, per port.
- req_addr  in  N_REQ x ADDR_W  beat address, per port.
- req_wdata  in  N_REQ x DATA_W  write data, per port.
- rsp_valid  out  N_REQ  one-cycle read data strobe, per port.
- rsp_rdata  out  DATA_W  read data, broadcast to all ports.
- ctl_valid  out  1  command to SDRAM controller.
- ctl_ready  in  1  controller accepts command.
- ctl_we, ctl_addr, ctl_wdata  out  1/ADDR_W/DATA_W  muxed command fields.
- ctl_rvalid  in  1  read data return, in issue order.
- ctl_rdata  in  DATA_W  read data.
- owner  out  clog2(N_REQ)  current grant holder (debug/LED).
- err_orphan  out  1  sticky: ctl_rvalid seen with tag FIFO empty.

Behaviour:
- Reset: state=ARB, owner=0, rr_ptr=RT_PORT, all wait counters 0, tag FIFO empty. Outputs req_ready=0, ctl_valid=0, rsp_valid=0, rsp_rdata=0, err_orphan=0.
- FSM ARB: combinationally selects a winner from req_valid and registers owner. Next state is LOCKED if any req_valid, otherwise stays in ARB. ARB never forwards a beat, so arbitration costs one cycle.
- Winner priority in ARB:
  - (1) lowest-index non-RT port with wait==STARVE_MAX and valid;
  - (2) RT_PORT if valid;
  - (3) first valid non-RT port searching upward from rr_ptr+1, wrapping modulo N_REQ.
  - rr_ptr is updated to the winner in cases (1) and (3) only.
- FSM LOCKED:
  - ctl_valid = req_valid[owner] && !blk; ctl_we/addr/wdata are muxed from owner.
  - req_ready[owner] = ctl_ready && !blk; every other ready is 0.
  - blk = !req_we[owner] && tag_full.
  - On accept (ctl_valid && ctl_ready) with req_last[owner]=1, return to ARB.
  - If owner drops valid mid-burst, stay LOCKED. Requesters must hold valid through the burst.
- Wait counters, one per non-RT port:
  - Increment (saturating at STARVE_MAX) each cycle the port has req_valid=1 and is not owner in LOCKED.
  - Clear on the cycle the port is registered as owner.
  - Counter width is clog2(STARVE_MAX+1).
- Tag FIFO:
  - Push owner id on each accepted read beat; pop on ctl_rvalid.
  - Push is refused while full even if a pop occurs in the same cycle (conservative; blk already prevents acceptance). Simultaneous push and pop when not full keeps the count unchanged.
  - ctl_rvalid with FIFO empty: no rsp_valid, set err_orphan.
- Response: rsp_valid[tag_head] and rsp_rdata are registered from ctl_rvalid/ctl_rdata, giving 1 cycle latency. rsp_rdata holds its last value otherwise.
- Writes produce no response and no tag.
- Reset mid-operation: everything returns to reset values immediately (async). Outstanding reads are forgotten, so late returns set err_orphan.

Decomposition:
- pkg additions:
  - arb_state_t enum {ARB, LOCKED};
  - dram_addr_t (logic [24:0]);
  - dram_word_t (logic [15:0]);
  - constant DRAM_PORT_VGA=0, DRAM_PORT_CPU=1, DRAM_PORT_UART=2.
- Sub-module dram_tag_fifo (WIDTH, DEPTH): synchronous FIFO with full/empty flags and a head output.

Test Plan (N_REQ=3, RT_PORT=0):
- Port 1 single read addr 0x0000100, last=1, ctl_ready=1 -> ARB cycle, next cycle ctl_valid with addr 0x0000100, we=0. Then ctl_rvalid with rdata 0xBEEF -> next cycle rsp_valid=3'b010 for 1 cycle, rsp_rdata=0xBEEF.
- Ports 1 and 2 continuously issue single-beat writes, port 0 idle -> ctl grants alternate 1,2,1,2, each beat separated by one ARB cycle.
- STARVE_MAX=8: port 0 continuous single beats, port 1 valid from t0 -> port 1 is granted at the first ARB after its counter reaches 8, then port 0 resumes.
- Port 2 four-beat write burst (last on beat 4), port 0 raises valid after beat 1 -> four consecutive ctl beats from port 2 (addr 0x10..0x13), then ARB, then port 0.
- MAX_OUTST=4, ctl_rvalid held 0, port 1 issues 6 single reads -> exactly 4 accepted and req_ready[1] stays 0. One ctl_rvalid -> the 5th read is accepted; responses return to port 1 in order.
- Assert rst during a LOCKED burst -> ctl_valid=0 and tag FIFO empty at once. A following ctl_rvalid produces no rsp_valid and sets err_orphan=1, which holds until the next rst.
